// File: rtl/cache_dm_wt.sv
// rtl/cache_dm_wt.sv - direct-mapped write-through data cache; CACHE_WRITE_ALLOCATE_EN enables write-allocate
module cache_dm_wt #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LAT        = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              C_MEM_CSN,
    input  logic              C_MEM_WEN,
    input  logic [ADDR_W-1:0] C_MEM_ADDR,
    input  logic [DATA_W-1:0] C_MEM_DI,
    output logic [DATA_W-1:0] C_MEM_DOUT,
    output logic              STALL,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [DATA_W-1:0] D_MEM_DI,
    input  logic [DATA_W-1:0] D_MEM_DOUT
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE) + 2;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WO_W  = OFF_W - 2;
    localparam logic [WO_W-1:0] LAST_WORD = WO_W'(WORDS_PER_LINE - 1);

`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam bit WRITE_ALLOCATE = 1'b1;
`else
    localparam bit WRITE_ALLOCATE = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_REFILL, ST_WRITE} state_t;

    state_t              state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_mem_q  [NUM_LINES];
    logic [DATA_W-1:0]   data_mem_q [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
    logic [WO_W-1:0]     iss_q, iss_d, rcv_q, rcv_d;
    logic [MEM_LAT-1:0]  rx_pipe_q, rx_pipe_d;
    logic                mem_csn_q, mem_csn_d;
    logic                mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_di_q, mem_di_d;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WO_W-1:0]     req_wo;
    logic [WO_W-1:0]     iss_nxt;
    logic                hit;
    logic                hit_wr_en;
    logic                cap_en;
    logic                stall_c;
    logic [DATA_W-1:0]   rdata_c;

    assign req_tag = C_MEM_ADDR[ADDR_W-1 -: TAG_W];
    assign req_idx = C_MEM_ADDR[OFF_W+IDX_W-1 : OFF_W];
    assign req_wo  = C_MEM_ADDR[OFF_W-1 : 2];
    assign hit     = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
    assign iss_nxt = iss_q + WO_W'(1);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        mem_csn_d  = 1'b1;
        mem_wen_d  = 1'b1;
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        hit_wr_en  = 1'b0;
        cap_en     = 1'b0;
        stall_c    = 1'b0;
        rdata_c    = '0;

        // Tracks which cycles hold returning read data, MEM_LAT cycles behind the issue.
        rx_pipe_d[0] = !mem_csn_q && mem_wen_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            rx_pipe_d[i] = rx_pipe_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (!C_MEM_CSN) begin
                    if (C_MEM_WEN && hit) begin
                        rdata_c = data_mem_q[req_idx][req_wo];
                    end else if (C_MEM_WEN || (!hit && WRITE_ALLOCATE)) begin
                        stall_c          = 1'b1;
                        valid_d[req_idx] = 1'b0;
                        fill_tag_d       = req_tag;
                        fill_idx_d       = req_idx;
                        iss_d            = '0;
                        rcv_d            = '0;
                        mem_csn_d        = 1'b0;
                        mem_addr_d       = {req_tag, req_idx, {WO_W{1'b0}}, 2'b00};
                        state_d          = ST_REFILL;
                    end else begin
                        stall_c    = 1'b1;
                        hit_wr_en  = hit;
                        mem_csn_d  = 1'b0;
                        mem_wen_d  = 1'b0;
                        mem_addr_d = C_MEM_ADDR;
                        mem_di_d   = C_MEM_DI;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_REFILL: begin
                stall_c = 1'b1;
                if (iss_q != LAST_WORD) begin
                    iss_d      = iss_nxt;
                    mem_csn_d  = 1'b0;
                    mem_addr_d = {fill_tag_q, fill_idx_q, iss_nxt, 2'b00};
                end
                if (rx_pipe_q[MEM_LAT-1]) begin
                    cap_en = 1'b1;
                    if (rcv_q == LAST_WORD) begin
                        valid_d[fill_idx_q] = 1'b1;
                        state_d             = ST_IDLE;
                    end else begin
                        rcv_d = rcv_q + WO_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            iss_q      <= '0;
            rcv_q      <= '0;
            rx_pipe_q  <= '0;
            mem_csn_q  <= 1'b1;
            mem_wen_q  <= 1'b1;
            mem_addr_q <= '0;
            mem_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            rx_pipe_q  <= rx_pipe_d;
            mem_csn_q  <= mem_csn_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge CLK) begin
        if (cap_en) begin
            data_mem_q[fill_idx_q][rcv_q] <= D_MEM_DOUT;
            if (rcv_q == LAST_WORD) begin
                tag_mem_q[fill_idx_q] <= fill_tag_q;
            end
        end
        if (hit_wr_en) begin
            data_mem_q[req_idx][req_wo] <= C_MEM_DI;
        end
    end

    assign STALL      = RSTn & stall_c;
    assign C_MEM_DOUT = RSTn ? rdata_c : '0;
    assign D_MEM_CSN  = mem_csn_q;
    assign D_MEM_WEN  = mem_wen_q;
    assign D_MEM_ADDR = mem_addr_q;
    assign D_MEM_DI   = mem_di_q;

endmodule

// File: tb/tb_cache_dm_wt.sv
// tb/tb_cache_dm_wt.sv - self-checking bench for cache_dm_wt; honours CACHE_WRITE_ALLOCATE_EN
module tb_cache_dm_wt;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int NUM_LINES = 8;
    localparam int WPL       = 4;
    localparam int MEM_LAT   = 1;
    localparam int LINE_B    = WPL * 4;

`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              C_MEM_CSN = 1'b1;
    logic              C_MEM_WEN = 1'b1;
    logic [ADDR_W-1:0] C_MEM_ADDR = '0;
    logic [DATA_W-1:0] C_MEM_DI = '0;
    logic [DATA_W-1:0] C_MEM_DOUT;
    logic              STALL;
    logic              D_MEM_CSN;
    logic              D_MEM_WEN;
    logic [ADDR_W-1:0] D_MEM_ADDR;
    logic [DATA_W-1:0] D_MEM_DI;
    logic [DATA_W-1:0] D_MEM_DOUT;

    cache_dm_wt #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES),
        .WORDS_PER_LINE(WPL), .MEM_LAT(MEM_LAT)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .C_MEM_CSN(C_MEM_CSN), .C_MEM_WEN(C_MEM_WEN), .C_MEM_ADDR(C_MEM_ADDR),
        .C_MEM_DI(C_MEM_DI), .C_MEM_DOUT(C_MEM_DOUT), .STALL(STALL),
        .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_ADDR(D_MEM_ADDR),
        .D_MEM_DI(D_MEM_DI), .D_MEM_DOUT(D_MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] lat_pipe [MEM_LAT];
    logic [11:0] rd_log[$];
    logic [11:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    bit          ref_valid [NUM_LINES];
    int          ref_tag   [NUM_LINES];

    // Synchronous memory: read data appears MEM_LAT cycles after the request.
    always @(posedge CLK) begin
        logic [31:0] rd;
        rd = mem[D_MEM_ADDR[11:2]];
        if (RSTn && !D_MEM_CSN) begin
            if (!D_MEM_WEN) begin
                mem[D_MEM_ADDR[11:2]] <= D_MEM_DI;
                wr_addr_log.push_back(D_MEM_ADDR);
                wr_data_log.push_back(D_MEM_DI);
            end else begin
                rd_log.push_back(D_MEM_ADDR);
            end
        end
        for (int i = MEM_LAT - 1; i > 0; i--) lat_pipe[i] <= lat_pipe[i-1];
        lat_pipe[0] <= rd;
    end
    assign D_MEM_DOUT = lat_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int line_idx(input int a);
        return (a / LINE_B) % NUM_LINES;
    endfunction

    function automatic int line_tag(input int a);
        return a / (LINE_B * NUM_LINES);
    endfunction

    task automatic predict(input logic wen, input int a, output int stall, output int nreads);
        bit hit;
        hit = ref_valid[line_idx(a)] && (ref_tag[line_idx(a)] == line_tag(a));
        if (wen) begin
            stall  = hit ? 0 : WPL + MEM_LAT + 1;
            nreads = hit ? 0 : WPL;
        end else if (hit || !ALLOC) begin
            stall  = 1;
            nreads = 0;
        end else begin
            stall  = WPL + MEM_LAT + 2;
            nreads = WPL;
        end
    endtask

    task automatic model_update(input logic wen, input int a, input logic [31:0] di);
        if (wen || ALLOC) begin
            ref_valid[line_idx(a)] = 1'b1;
            ref_tag[line_idx(a)]   = line_tag(a);
        end
        if (!wen) ref_mem[a / 4] = di;
    endtask

    task automatic run_req(input string name, input logic wen, input logic [11:0] a,
                           input logic [31:0] di, input int exp_stall, input int exp_nreads,
                           input logic [31:0] exp_data);
        int          stall_n;
        bit          timed_out;
        logic [31:0] rdata;
        int          base;
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        C_MEM_CSN  = 1'b0;
        C_MEM_WEN  = wen;
        C_MEM_ADDR = a;
        C_MEM_DI   = di;
        stall_n    = 0;
        timed_out  = 1'b0;
        forever begin
            @(negedge CLK);
            if (!STALL) break;
            stall_n++;
            if (stall_n > 64) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        rdata = C_MEM_DOUT;
        @(posedge CLK);
        #1;
        C_MEM_CSN = 1'b1;
        check({name, " timeout"}, 32'(timed_out), 32'd0);
        check({name, " stall"}, 32'(stall_n), 32'(exp_stall));
        check({name, " rdata"}, rdata, wen ? exp_data : 32'd0);
        check({name, " nreads"}, 32'(rd_log.size()), 32'(exp_nreads));
        base = int'(a) - (int'(a) % LINE_B);
        for (int k = 0; k < exp_nreads && k < rd_log.size(); k++)
            check({name, " beat_addr"}, {20'd0, rd_log[k]}, 32'(base + 4 * k));
        check({name, " nwrites"}, 32'(wr_addr_log.size()), wen ? 32'd0 : 32'd1);
        if (!wen && wr_addr_log.size() > 0) begin
            check({name, " wr_addr"}, {20'd0, wr_addr_log[0]}, {20'd0, a});
            check({name, " wr_data"}, wr_data_log[0], di);
        end
    endtask

    task automatic model_req(input string name, input logic wen, input logic [11:0] a,
                             input logic [31:0] di);
        int st;
        int nr;
        predict(wen, int'(a), st, nr);
        run_req(name, wen, a, di, st, nr, ref_mem[int'(a) / 4]);
        model_update(wen, int'(a), di);
    endtask

    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] di;
        int          stall;
        int          nreads;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[16]     = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;

        vecs[0] = '{1'b1, 12'h040, 32'h0, 6, 4, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 12'h048, 32'h0, 0, 0, 32'hC0DE0012};
        vecs[2] = '{1'b0, 12'h044, 32'h12345678, 1, 0, 32'h0};
        vecs[3] = '{1'b1, 12'h044, 32'h0, 0, 0, 32'h12345678};
        vecs[4] = '{1'b1, 12'h440, 32'h0, 6, 4, 32'hC0DE0110};
        vecs[5] = '{1'b1, 12'h040, 32'h0, 6, 4, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 12'h080, 32'hAABBCCDD, ALLOC ? 7 : 1, ALLOC ? 4 : 0, 32'h0};
        vecs[7] = '{1'b1, 12'h080, 32'h0, ALLOC ? 0 : 6, ALLOC ? 0 : 4, 32'hAABBCCDD};
        vecs[8] = '{1'b1, 12'h084, 32'h0, 0, 0, 32'hC0DE0021};

        // Reset with a request pending: no stall, no data, idle memory port.
        C_MEM_CSN  = 1'b0;
        C_MEM_ADDR = 12'h040;
        repeat (3) @(negedge CLK);
        check("rst stall", 32'(STALL), 32'd0);
        check("rst dout", C_MEM_DOUT, 32'd0);
        check("rst dcsn", 32'(D_MEM_CSN), 32'd1);
        check("rst dwen", 32'(D_MEM_WEN), 32'd1);
        check("rst daddr", {20'd0, D_MEM_ADDR}, 32'd0);
        check("rst ddi", D_MEM_DI, 32'd0);
        C_MEM_CSN = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        for (int v = 0; v < 9; v++) begin
            run_req($sformatf("vec%0d", v), vecs[v].wen, vecs[v].addr, vecs[v].di,
                    vecs[v].stall, vecs[v].nreads, vecs[v].rdata);
            model_update(vecs[v].wen, int'(vecs[v].addr), vecs[v].di);
        end

        // CSN released one cycle into a refill: the line still fills.
        C_MEM_CSN  = 1'b0;
        C_MEM_WEN  = 1'b1;
        C_MEM_ADDR = 12'h300;
        @(posedge CLK);
        #1;
        C_MEM_CSN = 1'b1;
        repeat (WPL + MEM_LAT + 2) @(posedge CLK);
        #1;
        model_update(1'b1, 12'h300, 32'h0);
        model_req("csn_drop_fill", 1'b1, 12'h308, 32'h0);

        // Reset asserted while beat 2 of a refill is on the bus.
        C_MEM_CSN  = 1'b0;
        C_MEM_WEN  = 1'b1;
        C_MEM_ADDR = 12'h100;
        repeat (3) @(posedge CLK);
        #2;
        check("beat2 dcsn", 32'(D_MEM_CSN), 32'd0);
        check("beat2 daddr", {20'd0, D_MEM_ADDR}, 32'h108);
        RSTn = 1'b0;
        #1;
        check("midrst dcsn", 32'(D_MEM_CSN), 32'd1);
        check("midrst stall", 32'(STALL), 32'd0);
        check("midrst dout", C_MEM_DOUT, 32'd0);
        C_MEM_CSN = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
        run_req("after_rst_100", 1'b1, 12'h100, 32'h0, WPL + MEM_LAT + 1, WPL, ref_mem[12'h100 / 4]);
        model_update(1'b1, 12'h100, 32'h0);
        model_req("after_rst_040", 1'b1, 12'h040, 32'h0);

        for (int n = 0; n < 200; n++) begin
            logic        wen;
            logic [11:0] a;
            logic [31:0] di;
            wen = ($urandom_range(0, 9) >= 3);
            a   = 12'($urandom_range(0, 3) * 128 + $urandom_range(0, 7) * 16 + $urandom_range(0, 3) * 4);
            di  = $urandom;
            model_req($sformatf("rnd%0d", n), wen, a, di);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
